// File: rtl/hex_word_sender_if.sv
// ---------------------------------------------------------------------------
// hex_word_sender_if
//   Handshake bundle for hex_word_sender: the upstream word port and the
//   downstream ASCII byte port to the UART transmitter.
//
//   Parameter:
//     NIBBLES     hex digits per word (1..8); data_in is 4*NIBBLES bits
//   Signals:
//     data_in     word to print
//     data_valid  upstream has a word
//     data_ready  sender can accept a word
//     tx_byte     ASCII character to the UART
//     tx_valid    tx_byte is valid
//     tx_ready    UART accepts tx_byte
//     busy        a word is in progress
//   Modports:
//     slave       the sender itself
//     master      the surroundings (producer + UART), e.g. a testbench
// ---------------------------------------------------------------------------
interface hex_word_sender_if #(
  parameter int NIBBLES = 4
);
  logic [4*NIBBLES-1:0] data_in;
  logic                 data_valid;
  logic                 data_ready;
  logic [7:0]           tx_byte;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 busy;

  modport slave (
    input  data_in, data_valid, tx_ready,
    output data_ready, tx_byte, tx_valid, busy
  );

  modport master (
    output data_in, data_valid, tx_ready,
    input  data_ready, tx_byte, tx_valid, busy
  );
endinterface

// File: rtl/hex_word_sender.sv
// ---------------------------------------------------------------------------
// hex_word_sender
//   Serializes one 4*NIBBLES-bit word into ASCII hex characters, MSB nibble
//   first, one character per tx handshake, for the UART transmit path.
//   Optional CR/LF terminator after each word when HEX_SENDER_CRLF_EN is
//   defined; without it the last digit returns the FSM to IDLE.
//
//   Parameter:
//     NIBBLES  hex digits per word, 1..8 (default 4)
//   Ports:
//     clk      rising-edge clock
//     rst_n    synchronous active-low reset
//     bus      hex_word_sender_if.slave (data_in/data_valid/data_ready,
//              tx_byte/tx_valid/tx_ready, busy)
//
//   tx_byte/tx_valid are registered; data_ready/busy decode the state.
// ---------------------------------------------------------------------------

// Nibble to uppercase ASCII hex digit.
module hex_to_ascii (
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);
  always_comb begin
    if (nibble < 4'd10) ascii = 8'h30 + {4'h0, nibble};
    else                ascii = 8'h37 + {4'h0, nibble};  // 'A' - 10
  end
endmodule

module hex_word_sender #(
  parameter int NIBBLES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  hex_word_sender_if.slave bus
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

`ifdef HEX_SENDER_CRLF_EN
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND_HEX = 2'd1,
    SEND_CR  = 2'd2,
    SEND_LF  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND_HEX = 2'd1
  } state_t;
`endif

  state_t         state_q, state_d;
  logic [W-1:0]   shift_q, shift_d;
  logic [CW-1:0]  cnt_q,   cnt_d;
  logic [7:0]     byte_q,  byte_d;
  logic           valid_q, valid_d;

  logic [W-1:0]   shift_next;
  logic [3:0]     nib_sel;
  logic [7:0]     nib_ascii;
  logic           tx_hs;

  // Word after dropping the nibble just sent. For NIBBLES=1 this is all
  // zeros, which is never used because the counter is already 0.
  assign shift_next = shift_q << 4;

  // One converter serves both the first digit (straight from data_in on the
  // accept cycle) and every following digit (top of the shifted word).
  assign nib_sel = (state_q == IDLE) ? bus.data_in[W-1 -: 4]
                                     : shift_next[W-1 -: 4];

  hex_to_ascii u_hex_to_ascii (
    .nibble (nib_sel),
    .ascii  (nib_ascii)
  );

  assign tx_hs          = valid_q && bus.tx_ready;
  assign bus.data_ready = (state_q == IDLE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.tx_byte    = byte_q;
  assign bus.tx_valid   = valid_q;

  // NOTE: every variable gets its hold value before the case statement, so
  // no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    byte_d  = byte_q;
    valid_d = valid_q;

    case (state_q)
      IDLE: begin
        if (bus.data_valid) begin
          shift_d = bus.data_in;
          cnt_d   = CW'(NIBBLES - 1);
          byte_d  = nib_ascii;
          valid_d = 1'b1;
          state_d = SEND_HEX;
        end
      end

      SEND_HEX: begin
        if (tx_hs) begin
          if (cnt_q != '0) begin
            shift_d = shift_next;
            cnt_d   = cnt_q - CW'(1);
            byte_d  = nib_ascii;
          end else begin
`ifdef HEX_SENDER_CRLF_EN
            byte_d  = 8'h0D;
            state_d = SEND_CR;
`else
            valid_d = 1'b0;
            state_d = IDLE;
`endif
          end
        end
      end

`ifdef HEX_SENDER_CRLF_EN
      SEND_CR: begin
        if (tx_hs) begin
          byte_d  = 8'h0A;
          state_d = SEND_LF;
        end
      end

      SEND_LF: begin
        if (tx_hs) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
`endif

      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Datapath registers. Reset clears the word in flight, so a reset mid-word
  // emits nothing further, not even a terminator.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
      byte_q  <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_hex_word_sender.sv
// ---------------------------------------------------------------------------
// tb_hex_word_sender
//   Directed bench for hex_word_sender. Two instances share clock/reset:
//   u_dut4 (NIBBLES=4) for formatting, backpressure, busy and reset tests,
//   u_dut1 (NIBBLES=1) for the full 0x0..0xF digit range. The CR/LF
//   terminator is expected only when HEX_SENDER_CRLF_EN is defined.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_hex_word_sender;

  logic clk;
  logic rst_n;

  int n_cmp;
  int n_bad;

  hex_word_sender_if #(.NIBBLES(4)) bus4 ();
  hex_word_sender_if #(.NIBBLES(1)) bus1 ();

  hex_word_sender #(.NIBBLES(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4.slave)
  );

  hex_word_sender #(.NIBBLES(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; outputs are sampled and inputs driven 1 ns after
  // the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Append CR/LF to an expected stream when the terminator is built in.
  task automatic add_term(inout logic [7:0] q[$]);
`ifdef HEX_SENDER_CRLF_EN
    q.push_back(8'h0D);
    q.push_back(8'h0A);
`endif
  endtask

  task automatic test_reset();
    rst_n           = 1'b0;
    bus4.data_in    = '0;
    bus4.data_valid = 1'b0;
    bus4.tx_ready   = 1'b0;
    bus1.data_in    = '0;
    bus1.data_valid = 1'b0;
    bus1.tx_ready   = 1'b0;
    repeat (3) step();
    n_cmp++;
    if (bus4.tx_valid !== 1'b0 || bus4.tx_byte !== 8'h00 ||
        bus4.busy !== 1'b0 || bus4.data_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_dut4: got valid=%b byte=%h busy=%b ready=%b, want 0 00 0 1",
               bus4.tx_valid, bus4.tx_byte, bus4.busy, bus4.data_ready);
    end
    n_cmp++;
    if (bus1.tx_valid !== 1'b0 || bus1.tx_byte !== 8'h00 ||
        bus1.busy !== 1'b0 || bus1.data_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_dut1: got valid=%b byte=%h busy=%b ready=%b, want 0 00 0 1",
               bus1.tx_valid, bus1.tx_byte, bus1.busy, bus1.data_ready);
    end
    rst_n = 1'b1;
    step();
    n_cmp++;
    if (bus4.tx_valid !== 1'b0 || bus4.data_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL post_reset_idle: got valid=%b ready=%b, want 0 1",
               bus4.tx_valid, bus4.data_ready);
    end
  endtask

  task automatic test_format();
    logic [7:0] exp_q[$];
    exp_q = '{8'h31, 8'h41, 8'h33, 8'h46};
    add_term(exp_q);
    bus4.tx_ready   = 1'b1;
    bus4.data_in    = 16'h1A3F;
    bus4.data_valid = 1'b1;
    step();                                   // accept edge
    bus4.data_valid = 1'b0;
    bus4.data_in    = 16'h0000;               // must not disturb the word
    foreach (exp_q[i]) begin
      n_cmp++;
      if (bus4.tx_valid !== 1'b1 || bus4.tx_byte !== exp_q[i] ||
          bus4.busy !== 1'b1 || bus4.data_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL format_byte%0d: got valid=%b byte=%h busy=%b ready=%b, want 1 %h 1 0",
                 i, bus4.tx_valid, bus4.tx_byte, bus4.busy, bus4.data_ready, exp_q[i]);
      end
      step();
    end
    n_cmp++;
    if (bus4.tx_valid !== 1'b0 || bus4.data_ready !== 1'b1 || bus4.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL format_end: got valid=%b ready=%b busy=%b, want 0 1 0",
               bus4.tx_valid, bus4.data_ready, bus4.busy);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_q[$];
    exp_q = '{8'h41, 8'h33, 8'h46};
    add_term(exp_q);
    bus4.tx_ready   = 1'b1;
    bus4.data_in    = 16'h1A3F;
    bus4.data_valid = 1'b1;
    step();
    bus4.data_valid = 1'b0;
    bus4.tx_ready   = 1'b0;
    // First char held for 4 cycles: ready low for 3, handshake on the 4th.
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (bus4.tx_valid !== 1'b1 || bus4.tx_byte !== 8'h31) begin
        n_bad++;
        $display("FAIL bp_hold%0d: got valid=%b byte=%h, want 1 31",
                 k, bus4.tx_valid, bus4.tx_byte);
      end
      bus4.tx_ready = (k == 3);
      step();
    end
    foreach (exp_q[i]) begin
      n_cmp++;
      if (bus4.tx_valid !== 1'b1 || bus4.tx_byte !== exp_q[i]) begin
        n_bad++;
        $display("FAIL bp_byte%0d: got valid=%b byte=%h, want 1 %h",
                 i, bus4.tx_valid, bus4.tx_byte, exp_q[i]);
      end
      step();
    end
    n_cmp++;
    if (bus4.tx_valid !== 1'b0 || bus4.data_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_end: got valid=%b ready=%b, want 0 1",
               bus4.tx_valid, bus4.data_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp1_q[$];
    logic [7:0] exp2_q[$];
    exp1_q = '{8'h31, 8'h41, 8'h33, 8'h46};
    add_term(exp1_q);
    exp2_q = '{8'h46, 8'h46, 8'h46, 8'h46};
    add_term(exp2_q);
    bus4.tx_ready   = 1'b1;
    bus4.data_in    = 16'h1A3F;
    bus4.data_valid = 1'b1;
    step();
    bus4.data_in    = 16'hFFFF;               // valid stays high while busy
    foreach (exp1_q[i]) begin
      n_cmp++;
      if (bus4.tx_valid !== 1'b1 || bus4.tx_byte !== exp1_q[i]) begin
        n_bad++;
        $display("FAIL b2b_w1_byte%0d: got valid=%b byte=%h, want 1 %h",
                 i, bus4.tx_valid, bus4.tx_byte, exp1_q[i]);
      end
      step();
    end
    // Exactly one idle cycle between words.
    n_cmp++;
    if (bus4.tx_valid !== 1'b0 || bus4.data_ready !== 1'b1 || bus4.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_gap: got valid=%b ready=%b busy=%b, want 0 1 0",
               bus4.tx_valid, bus4.data_ready, bus4.busy);
    end
    step();                                   // second accept edge
    bus4.data_valid = 1'b0;
    foreach (exp2_q[i]) begin
      n_cmp++;
      if (bus4.tx_valid !== 1'b1 || bus4.tx_byte !== exp2_q[i]) begin
        n_bad++;
        $display("FAIL b2b_w2_byte%0d: got valid=%b byte=%h, want 1 %h",
                 i, bus4.tx_valid, bus4.tx_byte, exp2_q[i]);
      end
      step();
    end
    n_cmp++;
    if (bus4.tx_valid !== 1'b0 || bus4.data_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_end: got valid=%b ready=%b, want 0 1",
               bus4.tx_valid, bus4.data_ready);
    end
  endtask

  task automatic test_reset_mid_word();
    int stray;
    bus4.tx_ready   = 1'b1;
    bus4.data_in    = 16'hBEEF;
    bus4.data_valid = 1'b1;
    step();
    bus4.data_valid = 1'b0;
    n_cmp++;
    if (bus4.tx_valid !== 1'b1 || bus4.tx_byte !== 8'h42) begin
      n_bad++;
      $display("FAIL rst_mid_b0: got valid=%b byte=%h, want 1 42",
               bus4.tx_valid, bus4.tx_byte);
    end
    step();
    n_cmp++;
    if (bus4.tx_valid !== 1'b1 || bus4.tx_byte !== 8'h45) begin
      n_bad++;
      $display("FAIL rst_mid_b1: got valid=%b byte=%h, want 1 45",
               bus4.tx_valid, bus4.tx_byte);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_cmp++;
    if (bus4.tx_valid !== 1'b0 || bus4.busy !== 1'b0 || bus4.data_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_mid_idle: got valid=%b busy=%b ready=%b, want 0 0 1",
               bus4.tx_valid, bus4.busy, bus4.data_ready);
    end
    stray = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (bus4.tx_valid !== 1'b0) stray++;
    end
    n_cmp++;
    if (stray != 0) begin
      n_bad++;
      $display("FAIL rst_mid_quiet: got %0d cycles with tx_valid, want 0", stray);
    end
  endtask

  task automatic test_digit_range();
    logic [7:0] ascii_tab [16];
    logic [7:0] exp_q[$];
    ascii_tab = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
                  8'h38, 8'h39, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
    bus1.tx_ready = 1'b1;
    for (int v = 0; v < 16; v++) begin
      exp_q = '{ascii_tab[v]};
      add_term(exp_q);
      bus1.data_in    = 4'(v);
      bus1.data_valid = 1'b1;
      step();
      bus1.data_valid = 1'b0;
      foreach (exp_q[i]) begin
        n_cmp++;
        if (bus1.tx_valid !== 1'b1 || bus1.tx_byte !== exp_q[i]) begin
          n_bad++;
          $display("FAIL digit_%h_byte%0d: got valid=%b byte=%h, want 1 %h",
                   v[3:0], i, bus1.tx_valid, bus1.tx_byte, exp_q[i]);
        end
        step();
      end
      n_cmp++;
      if (bus1.tx_valid !== 1'b0 || bus1.data_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL digit_%h_end: got valid=%b ready=%b, want 0 1",
                 v[3:0], bus1.tx_valid, bus1.data_ready);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_format();
    step();
    test_backpressure();
    step();
    test_back_to_back();
    step();
    test_reset_mid_word();
    test_digit_range();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hex_word_sender.md
# hex_word_sender

Serializes a multi-nibble data word into a stream of ASCII hexadecimal characters for the UART transmit path. Accepts one word over a valid/ready handshake, converts each nibble MSB-first with an internal `hex_to_ascii` instance, and emits one ASCII byte per downstream handshake. An optional CR/LF line terminator follows each word. Sits between the data-producing logic and the UART transmitter, which consumes `tx_byte`.

## Interface
- `NIBBLES`, default 4: number of hex digits per word. Legal range is 1–8. Word width is 4*NIBBLES.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `data_in`  in  4*NIBBLES  word to print; sampled on the accept cycle.
- `data_valid`  in  1  upstream has a word.
- `data_ready`  out  1  block can accept a word (high only in IDLE).
- `tx_byte`  out  8  ASCII character to the UART.
- `tx_valid`  out  1  `tx_byte` is valid.
- `tx_ready`  in  1  UART accepts `tx_byte`.
- `busy`  out  1  a word is in progress (state != IDLE).

## Operation
- FSM states: IDLE, SEND_HEX, SEND_CR, SEND_LF. SEND_CR and SEND_LF exist only with the macro enabled.
- IDLE: `data_ready`=1. On `data_valid && data_ready`:
  - latch `data_in` into a shift register;
  - set digit counter to NIBBLES-1;
  - load `tx_byte` with the ASCII of the top nibble;
  - go to SEND_HEX.
- SEND_HEX: `tx_valid`=1. On `tx_valid && tx_ready`:
  - if the counter is nonzero: shift the word left 4 bits, decrement the counter, and load `tx_byte` with the ASCII of the new top nibble;
  - if the counter is 0: go to SEND_CR with `tx_byte`=0x0D (macro on), or go to IDLE with `tx_valid`=0 (macro off).
- SEND_CR: on handshake, go to SEND_LF with `tx_byte`=0x0A.
- SEND_LF: on handshake, go to IDLE with `tx_valid`=0.
- Nibble mapping, via `hex_to_ascii`:
  - 0–9 → 0x30–0x39;
  - A–F → 0x41–0x46 (uppercase).
- Backpressure: while `tx_valid && !tx_ready`, `tx_byte`, the state, the counter and the shift register hold unchanged.
- `data_valid` outside IDLE is ignored. `data_in` changes after the accept cycle do not affect the word in flight.
- Reset mid-word: the word is discarded, with no partial terminator. The first post-reset cycle is IDLE.

## Timing
- Reset values:
  - state IDLE;
  - `tx_valid`=0, `tx_byte`=0x00, `busy`=0, `data_ready`=1;
  - shift register and counter are 0.
- `data_ready` and `busy` are decoded combinationally from the state register. `tx_byte` and `tx_valid` are registered.
- Latency: the accept edge makes the first character valid in the next cycle.
- Throughput: with `tx_ready` held high, one character per cycle with no bubbles.
- One word occupies 1 (accept) + NIBBLES + 2 cycles (macro on), or 1 + NIBBLES cycles (macro off).
- Back-to-back words: the last handshake returns to IDLE. `data_ready` is high in the following cycle, giving exactly one idle cycle between words.
- `tx_valid` is never deasserted without a completed handshake, except by reset.

## Configuration
- `HEX_SENDER_CRLF_EN` defined:
  - each word is followed by 0x0D then 0x0A;
  - states SEND_CR and SEND_LF are present.
- Undefined:
  - no terminator; SEND_CR and SEND_LF are not compiled;
  - the last hex digit returns the FSM to IDLE.

## Test plan
- Word formatting, NIBBLES=4, macro on, `tx_ready`=1: `data_in`=0x1A3F accepted → bytes 0x31, 0x41, 0x33, 0x46, 0x0D, 0x0A on consecutive cycles. Then `tx_valid`=0 and `data_ready`=1.
- Backpressure: same word with `tx_ready` low for 3 cycles after the first character → `tx_byte` holds 0x31 with `tx_valid`=1 for 4 cycles, and the sequence is otherwise unchanged.
- Ignored input while busy: `data_valid` held high with `data_in`=0xFFFF while busy → exactly one word is emitted per accept. The second word, 0xFFFF, starts only after one IDLE cycle → 0x46 ×4 then 0x0D, 0x0A.
- Reset mid-word: `rst_n` low for 1 cycle after the second character of 0xBEEF → next cycle `tx_valid`=0, `busy`=0, `data_ready`=1. No further bytes are emitted.
- Full digit range, all values 0x0–0xF: NIBBLES=1, macro off, words 0x0–0xF → single bytes 0x30–0x39, 0x41–0x46. Each word is followed by return to IDLE with no terminator.
